// File: rtl/chunked_adder.sv
// Multi-cycle adder/subtractor: processes CHUNK bits per clock, LSB chunk first,
// behind valid/ready handshakes on both the operand and the result side.
module chunked_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NCH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] part_r;
  logic             carry_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;
  logic             out_valid_r;

  logic [CHUNK-1:0] a_sl_s;
  logic [CHUNK-1:0] b_sl_s;
  logic [CHUNK-1:0] slice_s;
  logic             slice_cout_s;
  logic             msb_cin_s;
  logic [WIDTH-1:0] next_part_s;

  // One ripple-carry slice; the extra top bit is the chunk carry-out.
  function automatic logic [CHUNK:0] chunk_add(input logic [CHUNK-1:0] x,
                                               input logic [CHUNK-1:0] y,
                                               input logic             c);
    return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, c};
  endfunction

  // Current chunk slice and the partial result with that slice merged in.
  always_comb begin
    a_sl_s = a_r[cnt_r*CHUNK +: CHUNK];
    b_sl_s = b_r[cnt_r*CHUNK +: CHUNK];
    {slice_cout_s, slice_s} = chunk_add(a_sl_s, b_sl_s, carry_r);
    // Carry into the slice MSB recovered from the MSB sum bit; on the last chunk this is bit WIDTH-1.
    msb_cin_s = a_sl_s[CHUNK-1] ^ b_sl_s[CHUNK-1] ^ slice_s[CHUNK-1];
    next_part_s = part_r;
    next_part_s[cnt_r*CHUNK +: CHUNK] = slice_s;
  end

  // Control FSM, operand capture, chunk accumulation and registered result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      a_r         <= '0;
      b_r         <= '0;
      part_r      <= '0;
      carry_r     <= 1'b0;
      sum_r       <= '0;
      cout_r      <= 1'b0;
      ovf_r       <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r     <= a;
            b_r     <= sub ? ~b : b;
            carry_r <= sub ? 1'b1 : cin;
            cnt_r   <= '0;
            part_r  <= '0;
            state_r <= RUN;
          end
        end
        RUN: begin
          part_r  <= next_part_s;
          carry_r <= slice_cout_s;
          cnt_r   <= cnt_r + 1'b1;
          if (cnt_r == LAST_CNT) begin
            sum_r       <= next_part_s;
            cout_r      <= slice_cout_s;
            ovf_r       <= slice_cout_s ^ msb_cin_s;
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_r == IDLE) && !rst;
  assign out_valid = out_valid_r;
  assign sum       = sum_r;
  assign cout      = cout_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_chunked_adder.sv
// Bench for chunked_adder: four configurations driven from one stimulus bus and
// checked every cycle against an integer-arithmetic reference model.
module tb_chunked_adder;

  localparam int WS[4] = '{16, 16, 16, 32};
  localparam int NS[4] = '{4, 1, 16, 4};

  logic        clk = 1'b0;
  logic        rst;
  logic        started = 1'b0;
  logic [31:0] a_i, b_i;
  logic        cin_i, sub_i;
  logic [3:0]  in_valid, out_ready, in_ready, out_valid, cout_w, ovf_w;
  logic [15:0] s0, s1, s2;
  logic [31:0] s3;
  logic [31:0] sum_w [4];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic        pend [4];
  logic [31:0] exp_sum [4], last_sum [4];
  logic        exp_cout [4], exp_ovf [4], last_cout [4], last_ovf [4];
  int          acc_cyc [4];
  int          chk_acc [4];

  always #5 clk = ~clk;

  chunked_adder #(.WIDTH(16), .CHUNK(4)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a_i[15:0]), .b(b_i[15:0]), .cin(cin_i), .sub(sub_i),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .sum(s0), .cout(cout_w[0]), .ovf(ovf_w[0]));
  chunked_adder #(.WIDTH(16), .CHUNK(16)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a_i[15:0]), .b(b_i[15:0]), .cin(cin_i), .sub(sub_i),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .sum(s1), .cout(cout_w[1]), .ovf(ovf_w[1]));
  chunked_adder #(.WIDTH(16), .CHUNK(1)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a_i[15:0]), .b(b_i[15:0]), .cin(cin_i), .sub(sub_i),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .sum(s2), .cout(cout_w[2]), .ovf(ovf_w[2]));
  chunked_adder #(.WIDTH(32), .CHUNK(8)) u3 (
    .clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
    .a(a_i), .b(b_i), .cin(cin_i), .sub(sub_i),
    .out_valid(out_valid[3]), .out_ready(out_ready[3]),
    .sum(s3), .cout(cout_w[3]), .ovf(ovf_w[3]));

  assign sum_w[0] = {16'h0000, s0};
  assign sum_w[1] = {16'h0000, s1};
  assign sum_w[2] = {16'h0000, s2};
  assign sum_w[3] = s3;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endfunction

  // Reference: plain unsigned/signed integer arithmetic on a w-bit machine.
  function automatic void model(input int w, input logic [31:0] a, input logic [31:0] b,
                                input logic cin, input logic sub,
                                output logic [31:0] s, output logic co, output logic ov);
    longint mask, ua, ub, sa, sb, r, sv, lim;
    mask = (longint'(1) << w) - 1;
    lim  = longint'(1) << (w - 1);
    ua = longint'({32'h0, a}) & mask;
    ub = longint'({32'h0, b}) & mask;
    sa = (ua >= lim) ? ua - (mask + 1) : ua;
    sb = (ub >= lim) ? ub - (mask + 1) : ub;
    if (sub) begin
      r  = ua - ub;
      co = (ua >= ub);
      sv = sa - sb;
    end else begin
      r  = ua + ub + (cin ? 1 : 0);
      co = (r > mask);
      sv = sa + sb + (cin ? 1 : 0);
    end
    ov = (sv >= lim) || (sv < -lim);
    s  = 32'(r & mask);
  endfunction

  // Handshake monitor: records accepted operations and completed results.
  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int k = 0; k < 4; k++) begin
      if (rst) begin
        pend[k] = 1'b0;
        last_sum[k] = 32'h0; last_cout[k] = 1'b0; last_ovf[k] = 1'b0;
      end else begin
        if (in_valid[k] && in_ready[k]) begin
          model(WS[k], a_i, b_i, cin_i, sub_i, exp_sum[k], exp_cout[k], exp_ovf[k]);
          pend[k] = 1'b1;
          acc_cyc[k] = cyc;
        end
        if (out_valid[k] && out_ready[k] && pend[k]) begin
          pend[k] = 1'b0;
          last_sum[k] = exp_sum[k]; last_cout[k] = exp_cout[k]; last_ovf[k] = exp_ovf[k];
        end
      end
    end
  end

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    if (started && !rst) begin
      for (int k = 0; k < 4; k++) begin
        if (out_valid[k]) begin
          if (!pend[k]) begin
            check($sformatf("u%0d_spurious_valid", k), 32'(out_valid[k]), 32'd0);
          end else begin
            if (chk_acc[k] != acc_cyc[k]) begin
              chk_acc[k] = acc_cyc[k];
              check($sformatf("u%0d_latency", k), 32'(cyc - acc_cyc[k]), 32'(NS[k]));
            end
            check($sformatf("u%0d_sum", k), sum_w[k], exp_sum[k]);
            check($sformatf("u%0d_cout", k), 32'(cout_w[k]), 32'(exp_cout[k]));
            check($sformatf("u%0d_ovf", k), 32'(ovf_w[k]), 32'(exp_ovf[k]));
          end
        end else begin
          if (pend[k] && chk_acc[k] == acc_cyc[k])
            check($sformatf("u%0d_valid_dropped", k), 32'd0, 32'd1);
          check($sformatf("u%0d_sum_hold", k), sum_w[k], last_sum[k]);
          check($sformatf("u%0d_cout_hold", k), 32'(cout_w[k]), 32'(last_cout[k]));
          check($sformatf("u%0d_ovf_hold", k), 32'(ovf_w[k]), 32'(last_ovf[k]));
        end
      end
    end
  end

  task automatic do_op(input int k, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input logic sub, input int hold,
                       output logic [31:0] s, output logic co, output logic ov);
    int n;
    @(negedge clk);
    a_i = a; b_i = b; cin_i = cin; sub_i = sub; in_valid[k] = 1'b1;
    n = 0;
    while (!in_ready[k] && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) check("accept_timeout", 32'd0, 32'd1);
    @(negedge clk);
    in_valid[k] = 1'b0;
    a_i = $urandom; b_i = $urandom; cin_i = 1'($urandom); sub_i = 1'($urandom);
    n = 0;
    while (!out_valid[k] && n < 40) begin @(negedge clk); n++; end
    if (n >= 40) check("result_timeout", 32'd0, 32'd1);
    s = sum_w[k]; co = cout_w[k]; ov = ovf_w[k];
    for (int h = 0; h < hold; h++) begin
      in_valid[k] = 1'b1;
      check("bp_in_ready", 32'(in_ready[k]), 32'd0);
      @(negedge clk);
    end
    in_valid[k] = 1'b0;
    out_ready[k] = 1'b1;
    @(negedge clk);
    out_ready[k] = 1'b0;
    check("post_hs_in_ready", 32'(in_ready[k]), 32'd1);
    check("post_hs_out_valid", 32'(out_valid[k]), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] s;
    logic co, ov;
    for (int k = 0; k < 4; k++) begin chk_acc[k] = 0; acc_cyc[k] = 0; pend[k] = 1'b0; end
    rst = 1'b1; in_valid = 4'h0; out_ready = 4'h0;
    a_i = 32'h0; b_i = 32'h0; cin_i = 1'b0; sub_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", sum_w[0], 32'h0);
    check("rst_cout_ovf", 32'({cout_w, ovf_w}), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0; started = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'hF);

    do_op(0, 32'hFFFF, 32'h0001, 1'b0, 1'b0, 0, s, co, ov);
    check("wrap_sum", s, 32'h0000); check("wrap_cout", 32'(co), 32'd1); check("wrap_ovf", 32'(ov), 32'd0);
    do_op(0, 32'h7FFF, 32'h0001, 1'b0, 1'b0, 0, s, co, ov);
    check("sovf_sum", s, 32'h8000); check("sovf_cout", 32'(co), 32'd0); check("sovf_ovf", 32'(ov), 32'd1);
    do_op(0, 32'h1234, 32'h0001, 1'b1, 1'b0, 1, s, co, ov);
    check("cin_sum", s, 32'h1236); check("cin_cout", 32'(co), 32'd0); check("cin_ovf", 32'(ov), 32'd0);
    do_op(0, 32'h0005, 32'h0007, 1'b0, 1'b1, 0, s, co, ov);
    check("sub_sum", s, 32'hFFFE); check("sub_cout", 32'(co), 32'd0); check("sub_ovf", 32'(ov), 32'd0);
    do_op(0, 32'h8000, 32'h0001, 1'b1, 1'b1, 3, s, co, ov);
    check("subovf_sum", s, 32'h7FFF); check("subovf_cout", 32'(co), 32'd1); check("subovf_ovf", 32'(ov), 32'd1);

    // Abort an operation with reset on its second RUN edge.
    @(negedge clk);
    a_i = 32'h0101; b_i = 32'h0202; cin_i = 1'b0; sub_i = 1'b0; in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_out_valid", 32'(out_valid[0]), 32'd0);
    check("abort_sum", sum_w[0], 32'h0);
    check("abort_cout_ovf", 32'({cout_w[0], ovf_w[0]}), 32'd0);
    check("abort_in_ready_in_rst", 32'(in_ready[0]), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_in_ready", 32'(in_ready[0]), 32'd1);
    repeat (8) @(negedge clk);

    do_op(1, 32'hAAAA, 32'h5555, 1'b1, 1'b0, 0, s, co, ov);
    check("c16_sum", s, 32'h0000); check("c16_cout", 32'(co), 32'd1); check("c16_ovf", 32'(ov), 32'd0);
    do_op(2, 32'hAAAA, 32'h5555, 1'b1, 1'b0, 2, s, co, ov);
    check("c1_sum", s, 32'h0000); check("c1_cout", 32'(co), 32'd1); check("c1_ovf", 32'(ov), 32'd0);
    do_op(3, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 0, s, co, ov);
    check("w32_sum", s, 32'h7FFF_FFFF); check("w32_cout", 32'(co), 32'd1); check("w32_ovf", 32'(ov), 32'd1);

    for (int i = 0; i < 1000; i++)
      do_op(3, $urandom, $urandom, 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)), s, co, ov);

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/chunked_adder.md
# chunked_adder

Parametrised multi-cycle adder/subtractor. It adds or subtracts two WIDTH-bit operands CHUNK bits per clock, least-significant chunk first, using a ripple-carry chunk slice. It sits between a valid/ready producer and consumer in the datapath, where a full-width single-cycle carry chain would not meet timing or area. It reports carry-out and signed overflow with each result.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits processed per cycle; 1 ≤ CHUNK ≤ WIDTH.
- NCH (derived, not overridable), WIDTH/CHUNK, chunk count and RUN-phase cycle count.
- clk  input  1  single clock, all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operand request valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in for add; ignored when sub=1.
- sub  input  1  0 means a+b+cin; 1 means a−b, computed as a+~b+1.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  carry out of bit WIDTH−1; for sub, 1 means no borrow.
- ovf  output  1  two's-complement overflow: carry into bit WIDTH−1 XOR cout.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=(state==IDLE)&&!rst.
  - On in_valid&&in_ready, latch a, b (or ~b when sub=1) and the initial carry (sub ? 1 : cin).
  - Clear the chunk counter and go to RUN.
- RUN:
  - Each cycle, add one CHUNK slice of a and the latched b plus the running carry.
  - Store the slice into the partial result at position counter*CHUNK. Update the running carry. Record the carry into bit WIDTH−1 on the final chunk.
  - Increment the counter. When counter==NCH−1, go to DONE and load sum/cout/ovf in the same edge.
- DONE:
  - out_valid=1. Hold sum, cout and ovf stable.
  - On out_ready, go to IDLE.
  - No new operand is accepted in the DONE cycle, even with out_ready=1.
- sum, cout and ovf update only on the RUN→DONE edge. They hold their previous values in IDLE and RUN.
- Inputs a, b, cin and sub are sampled only at acceptance. Later changes to them have no effect.
- Reset values, effective after the edge with rst=1:
  - state=IDLE, counter=0.
  - out_valid=0, sum=0, cout=0, ovf=0.
  - in_ready=0 while rst is high, 1 in the first cycle after.
- Reset mid-RUN or in DONE: the operation is discarded and no result is produced.
- Reset has priority over every handshake in the same cycle.
- CHUNK==WIDTH: NCH=1, so a single RUN cycle.

## Timing
- Acceptance at edge E. RUN occupies edges E+1..E+NCH. out_valid is high from edge E+NCH.
- Latency is NCH cycles from acceptance to out_valid. The default configuration gives 4.
- Result handshake at edge D (out_valid&&out_ready). in_ready is high from edge D.
- Maximum throughput is one operation per NCH+2 cycles.
- out_valid, once asserted, stays high with stable data until out_ready is sampled high.
- The critical path is one CHUNK-bit carry chain plus the mux and register. It is independent of WIDTH.

## Test plan
Default configuration is WIDTH=16, CHUNK=4 unless stated.
- Add wrap: a=0xFFFF, b=0x0001, cin=0, sub=0 → sum=0x0000, cout=1, ovf=0. out_valid rises exactly 4 cycles after acceptance.
- Signed overflow: 0x7FFF+0x0001 → 0x8000, cout=0, ovf=1. Then cin=1 with 0x1234+0x0001 → 0x1236, cout=0, ovf=0.
- Subtract: 0x0005−0x0007 → 0xFFFE, cout=0, ovf=0. Then 0x8000−0x0001 with cin=1 (must be ignored) → 0x7FFF, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid.
  - sum, cout and ovf stay stable; in_ready stays 0; in_valid with new operands is not accepted.
  - After out_ready=1, in_ready rises the next cycle.
- Reset mid-RUN: assert rst on the 2nd RUN cycle.
  - The next cycle shows out_valid=0, sum=0 and the prior result cleared; in_ready=1 after rst is released.
  - No result appears for the aborted operation.
- Configuration sweep:
  - CHUNK=16: 0xAAAA+0x5555+1 → 0x0000, cout=1, latency 1.
  - CHUNK=1: latency 16 with the same result.
  - WIDTH=32, CHUNK=8: 0x80000000−0x00000001 → 0x7FFFFFFF, ovf=1. Check against a random reference model over 1000 operations.
